// File: rtl/branch_cond_unit.sv
// branch_cond_unit: registered branch-condition resolver for the KGP-RISC pipeline.
// Compares A against B (or zero in legacy mode), evaluates one of 16 condition
// codes, keeps an N/Z/C/V flag register and presents the taken/not-taken result
// through a one-entry valid/ready output stage.
// Optional macro BCU_PERF_CNT_EN adds saturating taken/not-taken handshake counters.
module branch_cond_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_use_zero,
  input  logic              in_flags_set,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_taken,
  output logic [3:0]        out_flags
`ifdef BCU_PERF_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  ntaken_cnt
`endif
);

  // Reject parameter values the datapath cannot support.
  if (DATA_W < 2 || CNT_W < 1) begin : g_param_check
    $error("branch_cond_unit: DATA_W must be >= 2 and CNT_W >= 1");
  end

  logic              out_valid_q, out_valid_d;
  logic              out_taken_q, out_taken_d;
  logic [3:0]        flags_q, flags_d;

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   diff;
  logic              flag_n, flag_z, flag_c, flag_v;
  logic              lt_s, lt_u;
  logic              taken;
  logic              accept;

  // Compare datapath: one wide subtract yields all four flags, then the condition code picks a result.
  always_comb begin
    b_eff  = in_use_zero ? '0 : in_b;
    diff   = {1'b0, in_a} - {1'b0, b_eff};
    flag_z = (in_a == b_eff);
    flag_n = diff[DATA_W-1];
    flag_c = diff[DATA_W];
    flag_v = (in_a[DATA_W-1] ^ b_eff[DATA_W-1]) & (diff[DATA_W-1] ^ in_a[DATA_W-1]);
    lt_s   = flag_n ^ flag_v;
    lt_u   = flag_c;
    taken  = 1'b0;
    case (in_op)
      4'd0:    taken = ~lt_s & ~flag_z;
      4'd1:    taken = lt_s;
      4'd2:    taken = flag_z;
      4'd3:    taken = 1'b0;
      4'd4:    taken = ~flag_z;
      4'd5:    taken = ~lt_s;
      4'd6:    taken = lt_s | flag_z;
      4'd7:    taken = 1'b1;
      4'd8:    taken = ~lt_u & ~flag_z;
      4'd9:    taken = lt_u;
      4'd10:   taken = ~lt_u;
      4'd11:   taken = lt_u | flag_z;
      4'd12:   taken = flags_q[2];
      4'd13:   taken = flags_q[3] ^ flags_q[0];
      4'd14:   taken = flags_q[1];
      default: taken = 1'b0;
    endcase
  end

  // Handshake and next-state: accept only when the output slot is empty or draining; flush kills the held result.
  always_comb begin
    in_ready    = rst_n & ~flush & (~out_valid_q | out_ready);
    accept      = in_valid & in_ready;
    out_valid_d = out_valid_q;
    out_taken_d = out_taken_q;
    flags_d     = flags_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_taken_d = taken;
      if (in_flags_set) begin
        flags_d = {flag_n, flag_z, flag_c, flag_v};
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output stage and flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_taken_q <= 1'b0;
      flags_q     <= 4'b0000;
    end else begin
      out_valid_q <= out_valid_d;
      out_taken_q <= out_taken_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_taken = out_taken_q;
  assign out_flags = flags_q;

`ifdef BCU_PERF_CNT_EN
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] ntaken_cnt_q, ntaken_cnt_d;
  logic             out_hs;

  // Performance counters: count delivered results by outcome, saturating; a flushed result is never delivered.
  always_comb begin
    out_hs       = out_valid_q & out_ready & ~flush;
    taken_cnt_d  = taken_cnt_q;
    ntaken_cnt_d = ntaken_cnt_q;
    if (cnt_clr) begin
      taken_cnt_d  = '0;
      ntaken_cnt_d = '0;
    end else if (out_hs) begin
      if (out_taken_q) begin
        if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + 1'b1;
      end else begin
        if (ntaken_cnt_q != '1) ntaken_cnt_d = ntaken_cnt_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken_cnt_q  <= '0;
      ntaken_cnt_q <= '0;
    end else begin
      taken_cnt_q  <= taken_cnt_d;
      ntaken_cnt_q <= ntaken_cnt_d;
    end
  end

  assign taken_cnt  = taken_cnt_q;
  assign ntaken_cnt = ntaken_cnt_q;
`endif

endmodule

// File: doc/branch_cond_unit.md
Name: branch_cond_unit

Overview:
Parameterised, registered branch-condition resolver for the KGP-RISC pipeline. It is the successor to the single-cycle compare-to-zero condition block.
- Compares operand A with operand B, or with zero in legacy mode.
- Supports 16 condition codes: signed, unsigned, flag-based, always and never.
- Keeps an architectural N/Z/C/V flag register.
- Delivers a taken/not-taken result through a one-entry valid/ready output stage to branch/PC logic.

Parameters:
DATA_W, 32, operand width in bits (>=2)
CNT_W, 16, performance counter width (used only with BCU_PERF_CNT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  kill any held result (pipeline flush)
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_op  in  4  condition code
in_a  in  DATA_W  operand A
in_b  in  DATA_W  operand B
in_use_zero  in  1  1: B replaced by 0 (legacy compare-to-zero)
in_flags_set  in  1  1: latch this compare's flags into flag register
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_taken  out  1  branch taken
out_flags  out  4  flag register {N,Z,C,V}

Behaviour:
- One clock, synchronous active-low reset (rst_n sampled on rising clk). Reset values:
  - out_valid=0, out_taken=0, out_flags=4'b0000.
  - in_ready=0 while rst_n=0.
- Compare datapath:
  - b_eff = in_use_zero ? 0 : in_b.
  - diff = {1'b0,in_a} - {1'b0,b_eff}, computed DATA_W+1 bits wide.
  - Z = (in_a==b_eff); N = diff[DATA_W-1]; C = diff[DATA_W] (borrow, i.e. A<B unsigned); V = signed overflow of A-B.
  - Signed lt = N^V.
- Condition codes (in_op):
  - 0 GT(s), 1 LT(s), 2 EQ, 3 NEVER. Codes 0-3 with in_use_zero=1 reproduce the legacy 2-bit opcond exactly.
  - 4 NE, 5 GE(s), 6 LE(s), 7 ALWAYS.
  - 8 GTU, 9 LTU, 10 GEU, 11 LEU.
  - 12 F_EQ (stored Z), 13 F_LT (stored N^V), 14 F_LTU (stored C).
  - 15 reserved: not taken.
- Flag-based codes (12-14) use the flag register value before any update from the same request.
- Handshake:
  - in_ready = rst_n & ~flush & (~out_valid | out_ready).
  - Accept when in_valid & in_ready. On the next edge: out_valid=1 and out_taken=result. Latency is 1 cycle.
  - While out_valid=1 & out_ready=0: out_valid, out_taken and out_flags hold stable; in_ready=0.
  - Back-to-back: out_ready=1 every cycle sustains 1 result/cycle.
  - If out_valid & out_ready and no accept, out_valid clears next edge.
- Flag register: on accept with in_flags_set=1, out_flags <= {N,Z,C,V} of this compare. Otherwise it holds.
- Flush:
  - flush=1 forces out_valid=0 at the next edge.
  - in_ready=0 during flush, so no accept and no flag update.
  - The flag register is not cleared by flush.
- Reset mid-operation: any held result is dropped and flags are cleared. The first accept is possible on the first cycle with rst_n=1.
- out_taken is meaningful only when out_valid=1. It holds its last value otherwise.

Optional Feature:
Macro BCU_PERF_CNT_EN.
- Defined:
  - Adds ports cnt_clr (in,1), taken_cnt (out,CNT_W) and ntaken_cnt (out,CNT_W).
  - On each output handshake (out_valid & out_ready), the counter matching out_taken increments, saturating at all-ones.
  - cnt_clr=1 or reset zeroes both counters. cnt_clr has priority over increment.
  - Flushed results are not counted.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Legacy mode: in_use_zero=1, a=5, op 0/1/2/3 -> taken 1/0/0/0. a=-3 (0xFFFFFFFD) -> 0/1/0/0. a=0 -> 0/0/1/0. Each result appears 1 cycle after accept.
- Signed vs unsigned: a=0xFFFFFFFF, b=1 -> LT(s)=1, LTU=0, GTU=1, GE(s)=0. a=0x80000000, b=1 with in_flags_set=1 -> out_flags V=1, N=0, C=0.
- Flags path: compare a=3, b=7 with in_flags_set=1, then F_LT, F_EQ, F_LTU with flags_set=0 -> taken 1/0/1. Same-cycle use of F_* sees the prior flags.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid/out_taken stable, exactly one accept. Then out_ready=1 streaming 4 requests -> 4 results in 4 consecutive cycles, in order.
- Flush/reset: flush while out_valid=1 & out_ready=0 -> out_valid=0 next cycle, no accept that cycle, flags unchanged. rst_n=0 for 1 cycle mid-stream -> out_valid=0, out_flags=0.
- BCU_PERF_CNT_EN, CNT_W=2: 5 taken handshakes -> taken_cnt=3 (saturated). 2 not-taken -> ntaken_cnt=2. cnt_clr simultaneous with a handshake -> both counters 0.
